vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator that derives a pixel-rate enable, horizontal and vertical sync, an active-video flag, and pixel coordinates from the single board clock. It also produces per-frame and per-second tick pulses for the temporizer and debouncer. Everything runs in one clock domain; no derived signal is ever used as a clock. It sits between the board clock pin and the pixel/character renderer.

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing derived from the board clock.
// Pixel enable, syncs, active flag, coordinates, frame and second ticks.
module vga_timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int TICK_FRAMES = 60,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             px_en,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_tick,
  output logic             sec_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W =
    (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX =
    FRM_W'(TICK_FRAMES - 1);

  localparam logic [CNT_W-1:0] X_MAX =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_MAX =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_L =
    CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_L =
    CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic             r_px;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_act;
  logic             r_ft;
  logic             r_st;
  logic [FRM_W-1:0] r_frm;

  logic             w_div_wrap;
  logic             w_step;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic             w_frame;
  logic             w_frm_wrap;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_hs_on;
  logic             w_vs_on;
  logic             w_act;

  assign w_div_wrap = (r_div == DIV_MAX);
  assign w_step     = en & r_px;
  assign w_x_wrap   = (r_x == X_MAX);
  assign w_y_wrap   = (r_y == Y_MAX);
  assign w_frame    = w_step & w_x_wrap & w_y_wrap;
  assign w_frm_wrap = (r_frm == FRM_MAX);

  assign w_x_nxt = w_x_wrap ? '0
                 : r_x + CNT_W'(1);
  assign w_y_nxt = !w_x_wrap ? r_y
                 : (w_y_wrap ? '0
                 : r_y + CNT_W'(1));

  // decode from the next position so the
  // registered syncs line up with x/y
  assign w_hs_on = (w_x_nxt >= HS_BEG)
                && (w_x_nxt < HS_END);
  assign w_vs_on = (w_y_nxt >= VS_BEG)
                && (w_y_nxt < VS_END);
  assign w_act   = (w_x_nxt < H_ACT_L)
                && (w_y_nxt < V_ACT_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_px  <= 1'b0;
    end else if (en) begin
      r_div <= w_div_wrap ? '0
             : r_div + DIV_W'(1);
      r_px  <= w_div_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= X_MAX;
      r_y   <= Y_MAX;
      r_hs  <= ~H_POL;
      r_vs  <= ~V_POL;
      r_act <= 1'b0;
    end else if (w_step) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_hs  <= w_hs_on ? H_POL : ~H_POL;
      r_vs  <= w_vs_on ? V_POL : ~V_POL;
      r_act <= w_act;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ft  <= 1'b0;
      r_st  <= 1'b0;
      r_frm <= '0;
    end else if (en) begin
      r_ft <= w_frame;
      r_st <= w_frame & w_frm_wrap;
      if (w_frame) begin
        r_frm <= w_frm_wrap ? '0
               : r_frm + FRM_W'(1);
      end
    end
  end

  // pulses are masked while frozen; the
  // pending state survives the pause
  assign px_en      = r_px & en;
  assign frame_tick = r_ft & en;
  assign sec_tick   = r_st & en;
  assign hsync      = r_hs;
  assign vsync      = r_vs;
  assign active     = r_act;
  assign x          = r_x;
  assign y          = r_y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three geometries of vga_timing_gen
// against an arithmetic raster model and fixed vectors.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        px;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ft;
    logic        st;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  typedef struct {
    int cd, ha, hf, hs, hb, va, vf, vs, vb, tf;
    bit hp, vp;
  } geo_t;

  typedef struct {
    logic en;
    logic px;
    int   x;
    int   y;
    logic act;
    logic hs;
    logic ft;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  longint n_en = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_en <= 0;
    else if (en) n_en <= n_en + 1;
  end

  logic d_px, d_hs, d_vs, d_act, d_ft, d_st;
  logic [10:0] d_x, d_y;
  logic s_px, s_hs, s_vs, s_act, s_ft, s_st;
  logic [3:0] s_x, s_y;
  logic p_px, p_hs, p_vs, p_act, p_ft, p_st;
  logic [4:0] p_x, p_y;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .px_en(d_px), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .x(d_x), .y(d_y),
    .frame_tick(d_ft), .sec_tick(d_st)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1),
    .H_SYNC(1), .H_BP(1), .V_ACTIVE(3),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .TICK_FRAMES(3), .CNT_W(4)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .en(en),
    .px_en(s_px), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .x(s_x), .y(s_y),
    .frame_tick(s_ft), .sec_tick(s_st)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(5), .H_FP(2),
    .H_SYNC(3), .H_BP(2), .V_ACTIVE(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1),
    .TICK_FRAMES(2), .CNT_W(5)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en),
    .px_en(p_px), .hsync(p_hs), .vsync(p_vs),
    .active(p_act), .x(p_x), .y(p_y),
    .frame_tick(p_ft), .sec_tick(p_st)
  );

  obs_t o_def, o_sml, o_pol;
  assign o_def = {d_px, d_hs, d_vs, d_act,
                  d_ft, d_st, 16'(d_x), 16'(d_y)};
  assign o_sml = {s_px, s_hs, s_vs, s_act,
                  s_ft, s_st, 16'(s_x), 16'(s_y)};
  assign o_pol = {p_px, p_hs, p_vs, p_act,
                  p_ft, p_st, 16'(p_x), 16'(p_y)};

  geo_t g_def, g_sml, g_pol;

  // e = enabled edges since reset; pixel
  // updates trail each px_en by one edge
  function automatic obs_t model(
    input geo_t g, input longint e, input bit en_i);
    obs_t m;
    longint ht, vt, p, pp, q, xx, yy;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    p  = (e == 0) ? 0 : (e - 1) / g.cd;
    pp = (e <= 1) ? 0 : (e - 2) / g.cd;
    if (p == 0) begin
      xx = ht - 1;
      yy = vt - 1;
    end else begin
      q  = p - 1;
      xx = q % ht;
      yy = (q / ht) % vt;
    end
    m     = '0;
    m.x   = 16'(xx);
    m.y   = 16'(yy);
    m.px  = en_i && (e != 0) && ((e % g.cd) == 0);
    m.act = (xx < g.ha) && (yy < g.va);
    m.hs  = (xx >= g.ha + g.hf &&
             xx < g.ha + g.hf + g.hs) ? g.hp : !g.hp;
    m.vs  = (yy >= g.va + g.vf &&
             yy < g.va + g.vf + g.vs) ? g.vp : !g.vp;
    m.ft  = en_i && (p != pp) && xx == 0 && yy == 0;
    m.st  = m.ft &&
            ((((p - 1) / (ht * vt)) + 1) % g.tf) == 0;
    return m;
  endfunction

  task automatic chk(input string nm,
                     input obs_t got, input obs_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display(
      "FAIL %s: got px=%b hs=%b vs=%b act=%b ft=%b st=%b x=%0d y=%0d, expected px=%b hs=%b vs=%b act=%b ft=%b st=%b x=%0d y=%0d",
      nm, got.px, got.hs, got.vs, got.act, got.ft,
      got.st, got.x, got.y, exp.px, exp.hs, exp.vs,
      exp.act, exp.ft, exp.st, exp.x, exp.y);
  endtask

  task automatic chk_int(input string nm,
                         input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vec_t tbl[9];
    int   t, f1, f2, lowlen, run, actn, xfall;
    int   found, ok, k, mask, tprev, dmin, dmax;
    int   vslow, vsbad;
    logic prev, snap_hs, snap_act;

    g_def = '{2, 640, 16, 96, 48, 480, 10, 2, 33,
              60, 1'b0, 1'b0};
    g_sml = '{1, 4, 1, 1, 1, 3, 1, 1, 1,
              3, 1'b0, 1'b0};
    g_pol = '{3, 5, 2, 3, 2, 4, 1, 2, 1,
              2, 1'b1, 1'b1};

    tbl[0] = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 799, 524, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1,   0,   0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0,   0,   0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0,   0,   0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0,   1,   0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1,   1,   0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0,   2,   0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    cyc();
    cyc();
    chk("reset_def", o_def, model(g_def, 0, en));
    chk("reset_sml", o_sml, model(g_sml, 0, en));
    chk("reset_pol", o_pol, model(g_pol, 0, en));
    chk_int("reset_x", int'(d_x), 799);

    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en;
      cyc();
      n_chk++;
      if (d_px === tbl[i].px && int'(d_x) == tbl[i].x &&
          int'(d_y) == tbl[i].y &&
          d_act === tbl[i].act && d_hs === tbl[i].hs &&
          d_ft === tbl[i].ft)
        n_pass++;
      else
        $display(
          "FAIL vec%0d: got px=%b x=%0d y=%0d act=%b hs=%b ft=%b, expected px=%b x=%0d y=%0d act=%b hs=%b ft=%b",
          i, d_px, d_x, d_y, d_act, d_hs, d_ft,
          tbl[i].px, tbl[i].x, tbl[i].y, tbl[i].act,
          tbl[i].hs, tbl[i].ft);
    end

    // horizontal timing on the default raster
    en = 1'b1;
    t = 0; f1 = -1; f2 = -1; lowlen = -1;
    run = 0; actn = 0; xfall = -1;
    prev = d_hs;
    for (int i = 0; i < 6000 && f2 < 0; i++) begin
      cyc();
      t++;
      if (f1 >= 0 && d_act) actn++;
      if (prev && !d_hs) begin
        if (f1 < 0) begin
          f1 = t;
          xfall = int'(d_x);
        end else f2 = t;
      end
      if (!d_hs) run++;
      if (!prev && d_hs && f1 >= 0 && lowlen < 0)
        lowlen = run;
      if (d_hs) run = 0;
      prev = d_hs;
    end
    chk_int("hs_start_x", xfall, 656);
    chk_int("hs_low_clk", lowlen, 192);
    chk_int("hs_period", f2 - f1, 1600);
    chk_int("act_per_line", actn, 1280);

    // freeze mid-line at x=100
    found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      cyc();
      if (int'(d_x) == 100) found = 1;
    end
    chk_int("reach_x100", found, 1);
    snap_hs  = d_hs;
    snap_act = d_act;
    ok = 1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (int'(d_x) != 100 || d_px !== 1'b0 ||
          d_hs !== snap_hs || d_act !== snap_act)
        ok = 0;
    end
    chk_int("freeze", ok, 1);
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cyc();
      if (d_px) found = 1;
    end
    chk_int("resume_px", found, 1);
    cyc();
    chk_int("resume_x", int'(d_x), 101);

    // asynchronous reset at x=300, y=10
    found = 0;
    for (int i = 0; i < 25000 && found == 0; i++) begin
      cyc();
      if (int'(d_x) == 300 && int'(d_y) == 10)
        found = 1;
    end
    chk_int("reach_mid", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_def", o_def, model(g_def, 0, en));
    chk("rst_mid_sml", o_sml, model(g_sml, 0, en));
    chk("rst_mid_pol", o_pol, model(g_pol, 0, en));
    chk_int("rst_mid_y", int'(d_y), 524);
    cyc();
    cyc();
    rst_n = 1'b1;

    // small raster: frame and second ticks restart
    k = 0; mask = 0; tprev = -1; t = 0;
    dmin = 1000; dmax = 0; vslow = 0; vsbad = 0;
    for (int i = 0; i < 500 && k < 9; i++) begin
      cyc();
      t++;
      if (k == 1 && !s_vs) begin
        vslow++;
        if (int'(s_y) != 4) vsbad++;
      end
      if (s_ft) begin
        k++;
        if (tprev >= 0) begin
          if (t - tprev < dmin) dmin = t - tprev;
          if (t - tprev > dmax) dmax = t - tprev;
        end
        tprev = t;
      end
      if (s_st) mask = mask | (1 << k);
    end
    chk_int("sml_ft_count", k, 9);
    chk_int("sml_ft_min", dmin, 42);
    chk_int("sml_ft_max", dmax, 42);
    chk_int("sml_sec_mask", mask,
            (1 << 3) | (1 << 6) | (1 << 9));
    chk_int("sml_vs_low", vslow, 7);
    chk_int("sml_vs_line", vsbad, 0);

    // random run enable against the model
    for (int i = 0; i < 4000; i++) begin
      en = (($urandom % 10) < 8);
      cyc();
      chk("rnd_def", o_def, model(g_def, n_en, en));
      chk("rnd_sml", o_sml, model(g_sml, n_en, en));
      chk("rnd_pol", o_pol, model(g_pol, n_en, en));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
